// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - AHB3-Lite bus encodings and SRAM slave state type
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_e;

    // Byte lanes touched by a transfer of the given size, before shifting to its offset.
    function automatic logic [7:0] size_lane_mask(input logic [2:0] size);
        case (size)
            HSIZE_BYTE:  size_lane_mask = 8'h01;
            HSIZE_HWORD: size_lane_mask = 8'h03;
            HSIZE_WORD:  size_lane_mask = 8'h0F;
            default:     size_lane_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ahb3lite_sram_mem.sv
// rtl/ahb3lite_sram_mem.sv - single-port synchronous SRAM with byte-enable write
// Ports: clk; re (read strobe, rdata updates next edge and holds otherwise);
//        we (per-byte write enables); addr (word index); wdata; rdata.
// Contents are not reset.
module ahb3lite_sram_mem
    import ahb3lite_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                re,
    input  logic [DATA_W/8-1:0] we,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// rtl/ahb3lite_sram_slave.sv - AHB3-Lite SRAM slave with wait states, error checks and write bypass
// Ports: HCLK, HRESET (async, active-high); address phase HSEL/HADDR/HWRITE/HSIZE/HTRANS
//        (HBURST/HPROT/HMASTLOCK ignored); HREADY from interconnect; HWDATA in data phase;
//        HRDATA/HREADYOUT/HRESP data-phase response.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int BYTES     = HDATA_SIZE / 8;
    localparam int ADDR_LSB  = $clog2(BYTES);
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam int RANGE_LSB = ADDR_LSB + MEM_AW;
    localparam int AQ_W      = ADDR_LSB + MEM_AW;
    localparam int CNT_W     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_STATES);

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK};

    slave_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              xfer_q, xfer_d;
    logic              write_q, write_d;
    logic [AQ_W-1:0]   addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;

    // Read bypass captured at read launch: bytes newer than the SRAM copy.
    logic [BYTES-1:0]      byp_be_q, byp_be_d;
    logic [HDATA_SIZE-1:0] byp_data_q, byp_data_d;

    // One-entry write buffer: holds a completing write that lost the port to a read launch.
    logic                  wb_valid_q, wb_valid_d;
    logic [MEM_AW-1:0]     wb_addr_q, wb_addr_d;
    logic [BYTES-1:0]      wb_be_q, wb_be_d;
    logic [HDATA_SIZE-1:0] wb_data_q, wb_data_d;

    logic                  accept, legal, addr_oor, size_bad, align_bad;
    logic                  finish, wr_now, rd_launch;
    logic [MEM_AW-1:0]     in_word, q_word;
    logic [BYTES-1:0]      wr_be;
    logic                  mem_re;
    logic [BYTES-1:0]      mem_we;
    logic [MEM_AW-1:0]     mem_addr;
    logic [HDATA_SIZE-1:0] mem_wdata, mem_rdata, merged;

    always_comb begin
        accept    = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
        addr_oor  = (HADDR >> RANGE_LSB) != '0;
        size_bad  = HSIZE > 3'(ADDR_LSB);
        align_bad = (HADDR[7:0] & 8'((16'd1 << HSIZE) - 16'd1)) != 8'd0;
        legal     = !(addr_oor || size_bad || align_bad);
        in_word   = HADDR[ADDR_LSB +: MEM_AW];
        q_word    = addr_q[ADDR_LSB +: MEM_AW];
        wr_be     = BYTES'(size_lane_mask(size_q) << addr_q[ADDR_LSB-1:0]);
        finish    = xfer_q && hreadyout_q;
        wr_now    = finish && write_q;
        rd_launch = accept && legal && !HWRITE;
        cnt_inc   = cnt_q + 1'b1;
    end

    // Transfer sequencing and registered response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xfer_d      = xfer_q;
        write_d     = write_q;
        addr_d      = addr_q;
        size_d      = size_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        if (accept) begin
            write_d = HWRITE;
            addr_d  = HADDR[AQ_W-1:0];
            size_d  = HSIZE;
            cnt_d   = '0;
            if (!legal) begin
                state_d     = ST_ERR1;
                xfer_d      = 1'b0;
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
                state_d     = ST_WAIT;
                xfer_d      = 1'b1;
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_OKAY;
            end else begin
                state_d     = ST_IDLE;
                xfer_d      = 1'b1;
                hreadyout_d = 1'b1;
                hresp_d     = HRESP_OKAY;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d       = cnt_inc;
                        hreadyout_d = (cnt_inc == CNT_MAX);
                    end else begin
                        state_d     = ST_IDLE;
                        xfer_d      = 1'b0;
                        hreadyout_d = 1'b1;
                        hresp_d     = HRESP_OKAY;
                    end
                end
                ST_ERR1: begin
                    state_d     = ST_ERR2;
                    hreadyout_d = 1'b1;
                    hresp_d     = HRESP_ERROR;
                end
                default: begin
                    state_d     = ST_IDLE;
                    xfer_d      = 1'b0;
                    hreadyout_d = 1'b1;
                    hresp_d     = HRESP_OKAY;
                end
            endcase
        end
    end

    // SRAM port arbitration: read launch first, then a completing write, then the buffer.
    // A buffered write is always drained before the next write completes, because the
    // cycle that accepts that write never launches a read.
    always_comb begin
        mem_re     = rd_launch;
        mem_addr   = in_word;
        mem_we     = '0;
        mem_wdata  = HWDATA;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_be_d    = wb_be_q;
        wb_data_d  = wb_data_q;
        byp_be_d   = byp_be_q;
        byp_data_d = byp_data_q;
        if (!rd_launch) begin
            if (wr_now) begin
                mem_addr = q_word;
                mem_we   = wr_be;
            end else if (wb_valid_q) begin
                mem_addr   = wb_addr_q;
                mem_we     = wb_be_q;
                mem_wdata  = wb_data_q;
                wb_valid_d = 1'b0;
            end
        end else begin
            if (wr_now) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = q_word;
                wb_be_d    = wr_be;
                wb_data_d  = HWDATA;
            end
            byp_be_d   = '0;
            byp_data_d = '0;
            if (wr_now && q_word == in_word) begin
                byp_be_d   = wr_be;
                byp_data_d = HWDATA;
            end else if (wb_valid_q && wb_addr_q == in_word) begin
                byp_be_d   = wb_be_q;
                byp_data_d = wb_data_q;
            end
        end
    end

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < BYTES; i++) begin
            if (byp_be_q[i]) begin
                merged[8*i +: 8] = byp_data_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            xfer_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            byp_be_q    <= '0;
            byp_data_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_be_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xfer_q      <= xfer_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            byp_be_q    <= byp_be_d;
            byp_data_q  <= byp_data_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_be_q     <= wb_be_d;
            wb_data_q   <= wb_data_d;
        end
    end

    ahb3lite_sram_mem #(
        .DATA_W (HDATA_SIZE),
        .DEPTH  (MEM_DEPTH),
        .AW     (MEM_AW)
    ) u_mem (
        .clk   (HCLK),
        .re    (mem_re),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (finish && !write_q) ? merged : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// tb/tb_ahb3lite_sram_slave.sv - scoreboard bench for ahb3lite_sram_slave at 0 and 3 wait states
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] haddr, hwdata;
    logic        hwrite, hmastlock;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hrdata [2];
    logic        hreadyout [2];
    logic        hresp [2];

    int checks = 0;
    int failures = 0;
    int ws_of [2] = '{0, 3};
    logic [31:0] model_mem [2][256];
    cmd_t cmd_q [$];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(sel[0]), .HADDR(haddr), .HWDATA(hwdata), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
        .HREADY(hreadyout[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
    );

    ahb3lite_sram_slave #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(sel[1]), .HADDR(haddr), .HWDATA(hwdata), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HMASTLOCK(hmastlock),
        .HREADY(hreadyout[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Queue a transfer and its expected response, updating the reference memory in bus order.
    task automatic push(input int d, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata);
        cmd_t c;
        exp_t e;
        bit   bad;
        int   w;
        int   off;
        bad = ((addr >> 2) >= 256) || ((1 << size) > 4) || ((addr % (1 << size)) != 0);
        c.wr = wr; c.addr = addr; c.size = size; c.wdata = wdata;
        e.resp = bad;
        e.waits = bad ? 1 : ws_of[d];
        e.rdata = 32'h0;
        if (!bad) begin
            w = int'(addr >> 2);
            off = int'(addr % 4);
            if (wr) begin
                for (int i = 0; i < (1 << size); i++) begin
                    model_mem[d][w][8*(off+i) +: 8] = wdata[8*(off+i) +: 8];
                end
            end else begin
                e.rdata = model_mem[d][w];
            end
        end
        cmd_q.push_back(c);
        exp_q.push_back(e);
    endtask

    // Pipelined master: drives queued transfers back to back, checks each data phase.
    task automatic run(input int d);
        cmd_t dp;
        exp_t de;
        bit   have = 0;
        int   waits = 0;
        int   budget = 0;
        while ((cmd_q.size() > 0 || have) && budget < 500) begin
            if (cmd_q.size() > 0) begin
                sel    = 2'b01 << d;
                htrans = HTRANS_NONSEQ;
                haddr  = cmd_q[0].addr;
                hwrite = cmd_q[0].wr;
                hsize  = cmd_q[0].size;
            end else begin
                sel    = 2'b00;
                htrans = HTRANS_IDLE;
            end
            hwdata = have ? dp.wdata : 32'h0;
            @(negedge clk);
            if (have) begin
                if (hreadyout[d]) begin
                    check("wait_cycles", 32'(waits), 32'(de.waits));
                    check("hresp_final", 32'(hresp[d]), 32'(de.resp));
                    if (!dp.wr || de.resp) begin
                        check("hrdata", hrdata[d], de.rdata);
                    end
                    have = 0;
                end else begin
                    waits++;
                    check("hresp_wait", 32'(hresp[d]), 32'(de.resp));
                end
            end
            if (hreadyout[d] && cmd_q.size() > 0) begin
                dp = cmd_q.pop_front();
                de = exp_q.pop_front();
                have = 1;
                waits = 0;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 500) begin
            check("run_timeout", 32'd1, 32'd0);
        end
        sel    = 2'b00;
        htrans = HTRANS_IDLE;
    endtask

    initial begin
        rst = 1'b1;
        sel = 2'b00;
        haddr = 32'h0;
        hwdata = 32'h0;
        hwrite = 1'b0;
        hsize = HSIZE_WORD;
        hburst = HBURST_SINGLE;
        hprot = 4'h3;
        htrans = HTRANS_IDLE;
        hmastlock = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                model_mem[d][i] = 32'h0;
            end
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_hreadyout", 32'(hreadyout[d]), 32'd1);
            check("rst_hresp", 32'(hresp[d]), 32'd0);
            check("rst_hrdata", hrdata[d], 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero wait states: pipelining, bypass, byte lanes, errors, top word.
        push(0, 1, 32'h000, HSIZE_WORD, 32'h0000_0000);
        push(0, 1, 32'h020, HSIZE_WORD, 32'h0000_0000);
        push(0, 1, 32'h010, HSIZE_WORD, 32'h1234_5678);
        push(0, 0, 32'h010, HSIZE_WORD, 32'h0);
        push(0, 1, 32'h021, HSIZE_BYTE, 32'hABAB_ABAB);
        push(0, 0, 32'h020, HSIZE_WORD, 32'h0);
        push(0, 1, 32'h012, HSIZE_HWORD, 32'hBEEF_BEEF);
        push(0, 1, 32'h400, HSIZE_WORD, 32'hDEAD_BEEF);
        push(0, 0, 32'h000, HSIZE_WORD, 32'h0);
        push(0, 0, 32'h003, HSIZE_HWORD, 32'h0);
        push(0, 0, 32'h008, HSIZE_DWORD, 32'h0);
        push(0, 0, 32'h010, HSIZE_WORD, 32'h0);
        push(0, 1, 32'h3FC, HSIZE_WORD, 32'hA5A5_5A5A);
        push(0, 0, 32'h3FC, HSIZE_WORD, 32'h0);
        push(0, 1, 32'h024, HSIZE_WORD, 32'h0102_0304);
        push(0, 0, 32'h020, HSIZE_WORD, 32'h0);
        push(0, 0, 32'h024, HSIZE_WORD, 32'h0);
        run(0);

        // Three wait states: wait timing, bypass with waits, error then ERR2 acceptance.
        push(1, 1, 32'h000, HSIZE_WORD, 32'hCAFE_F00D);
        push(1, 0, 32'h000, HSIZE_WORD, 32'h0);
        push(1, 1, 32'h040, HSIZE_WORD, 32'h1111_2222);
        push(1, 1, 32'h401, HSIZE_BYTE, 32'h0);
        push(1, 0, 32'h040, HSIZE_WORD, 32'h0);
        run(1);

        // Reset pulsed in the second wait cycle of a write to 0x40.
        sel = 2'b10;
        htrans = HTRANS_NONSEQ;
        haddr = 32'h040;
        hwrite = 1'b1;
        hsize = HSIZE_WORD;
        @(posedge clk);
        #1;
        sel = 2'b00;
        htrans = HTRANS_IDLE;
        hwdata = 32'h9999_9999;
        @(posedge clk);
        #1;
        check("pre_rst_hreadyout", 32'(hreadyout[1]), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_hreadyout", 32'(hreadyout[1]), 32'd1);
        check("abort_hresp", 32'(hresp[1]), 32'd0);
        check("abort_hrdata", hrdata[1], 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(1, 0, 32'h040, HSIZE_WORD, 32'h0);
        push(1, 0, 32'h000, HSIZE_WORD, 32'h0);
        run(1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
